// File: rtl/gauss_sample_buffer.sv
// gauss_sample_buffer
//   First-word-fall-through FIFO that decouples a Box-Muller stage, which
//   produces two samples per cycle, from a consumer that takes one sample
//   per cycle. Samples flagged as overflowed are dropped and counted.
//   Defining GSB_CLIP_EN writes them as saturated values instead, and
//   drop_cnt then counts the clipped samples.
//
// Parameters
//   DEPTH  FIFO entries (power of two, >= 4)
//   CNT_W  width of drop_cnt
//
// Ports
//   clk, rst             clock, synchronous active-high reset
//   in_valid/in_ready    pair handshake (in_ready depends on registered state only)
//   in_s1, in_s2         sin / cos path samples
//   in_ovr1, in_ovr2     overflow flags for in_s1 / in_s2
//   out_valid/out_ready  sample handshake
//   out_data, out_ch     head sample and its source (0 = s1, 1 = s2)
//   level                current occupancy
//   drop_cnt             saturating count of overflowed samples
module gauss_sample_buffer #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_s1,
  input  logic [31:0]              in_s2,
  input  logic                     in_ovr1,
  input  logic                     in_ovr2,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_data,
  output logic                     out_ch,
  output logic [$clog2(DEPTH):0]   level,
  output logic [CNT_W-1:0]         drop_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  // Each entry is {channel, sample}. The head is read combinationally so
  // a sample is visible the cycle after it is written.
  logic [32:0]      mem [DEPTH];

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic             push, pop;
  logic             wr1, wr2;
  logic [31:0]      dat1, dat2;
  logic [AW-1:0]    addr2;
  logic [1:0]       nwr, novr;
  logic [CNT_W:0]   drop_sum;
  logic [32:0]      head;

`ifdef GSB_CLIP_EN
  function automatic logic [31:0] sat(input logic [31:0] s);
    return s[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
  endfunction
`endif

  always_comb begin
    // Room for a full pair is required, so readiness never depends on out_ready.
    in_ready = (level_q <= LW'(DEPTH - 2));
    out_valid = (level_q != '0);
    push = in_valid && in_ready;
    pop  = out_valid && out_ready;

`ifdef GSB_CLIP_EN
    wr1  = push;
    wr2  = push;
    dat1 = in_ovr1 ? sat(in_s1) : in_s1;
    dat2 = in_ovr2 ? sat(in_s2) : in_s2;
`else
    wr1  = push && !in_ovr1;
    wr2  = push && !in_ovr2;
    dat1 = in_s1;
    dat2 = in_s2;
`endif

    // s2 lands right after s1 when both are written, else in s1's slot.
    // Pointer arithmetic wraps naturally because DEPTH is a power of two.
    addr2 = wr_ptr_q + AW'(wr1);
    nwr   = {1'b0, wr1} + {1'b0, wr2};
    novr  = {1'b0, push && in_ovr1} + {1'b0, push && in_ovr2};

    wr_ptr_d = wr_ptr_q + AW'(nwr);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_q + LW'(nwr) - LW'(pop);

    // One extra bit catches the carry so the counter pins at all-ones.
    drop_sum = {1'b0, drop_q} + (CNT_W + 1)'(novr);
    drop_d   = drop_sum[CNT_W] ? {CNT_W{1'b1}} : drop_sum[CNT_W-1:0];

    head     = mem[rd_ptr_q];
    out_data = head[31:0];
    out_ch   = head[32];
    level    = level_q;
    drop_cnt = drop_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  // Storage carries no reset; reset only blocks writes so a push coinciding
  // with reset leaves nothing behind.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (wr1) mem[wr_ptr_q] <= {1'b0, dat1};
      if (wr2) mem[addr2]    <= {1'b1, dat2};
    end
  end

endmodule

// File: tb/tb_gauss_sample_buffer.sv
`timescale 1ns/1ps
module tb_gauss_sample_buffer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_s1 = '0, in_s2 = '0;
  logic        in_ovr1 = 1'b0, in_ovr2 = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_data;
  logic        out_ch;
  logic [3:0]  level;
  logic [15:0] drop_cnt;

  // Second instance with a narrow drop counter for saturation
  logic        b_in_valid = 1'b0, b_in_ready;
  logic [31:0] b_s1 = 32'h0000_0001, b_s2 = 32'h0000_0002;
  logic        b_out_valid, b_out_ready = 1'b0;
  logic [31:0] b_out_data;
  logic        b_out_ch;
  logic [3:0]  b_level;
  logic [3:0]  b_drop;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  gauss_sample_buffer #(.DEPTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_s1(in_s1), .in_s2(in_s2), .in_ovr1(in_ovr1), .in_ovr2(in_ovr2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_ch(out_ch),
    .level(level), .drop_cnt(drop_cnt)
  );

  gauss_sample_buffer #(.DEPTH(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_s1(b_s1), .in_s2(b_s2), .in_ovr1(1'b1), .in_ovr2(1'b1),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_data(b_out_data), .out_ch(b_out_ch),
    .level(b_level), .drop_cnt(b_drop)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Sample point is 1 ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_pair(input logic [31:0] s1, input logic [31:0] s2,
                           input logic o1, input logic o2);
    in_valid = 1'b1; in_s1 = s1; in_s2 = s2; in_ovr1 = o1; in_ovr2 = o2;
    tick();
    in_valid = 1'b0; in_ovr1 = 1'b0; in_ovr2 = 1'b0;
  endtask

  logic [31:0] exp_q [$];
  int          r, k, lvl_m, errs, cyc;
  logic        push_now;

  initial begin
    // Reset
    tick(); tick();
    rst = 1'b0;
    chk("rst_level", level, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_drop", drop_cnt, 0);

    // Single pair, fall-through then pop each cycle
    out_ready = 1'b1;
    push_pair(32'h11, 32'h22, 1'b0, 1'b0);
    chk("p1_valid", out_valid, 1);
    chk("p1_data", out_data, 32'h11);
    chk("p1_ch", out_ch, 0);
    tick();
    chk("p2_data", out_data, 32'h22);
    chk("p2_ch", out_ch, 1);
    tick();
    chk("p3_valid", out_valid, 0);
    chk("p3_level", level, 0);
    $display("pair 11/22 streamed through");

    // Fill to full with out_ready low
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push_pair(32'h100 + 32'(2*i), 32'h101 + 32'(2*i), 1'b0, 1'b0);
      if (i == 2) begin
        chk("fill3_level", level, 6);
        chk("fill3_ready", in_ready, 1);
      end
    end
    chk("full_level", level, 8);
    chk("full_ready", in_ready, 0);
    in_valid = 1'b1; in_s1 = 32'h200; in_s2 = 32'h201;
    tick();
    chk("held_level", level, 8);
    chk("held_data", out_data, 32'h100);
    chk("held_ch", out_ch, 0);
    out_ready = 1'b1;
    tick();
    chk("pop1_level", level, 7);
    chk("pop1_ready", in_ready, 0);
    chk("pop1_data", out_data, 32'h101);
    tick();
    chk("pop2_level", level, 6);
    chk("pop2_ready", in_ready, 1);
    out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("refill_level", level, 8);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      chk("drain_data", out_data, (i < 6) ? 32'h102 + 32'(i) : 32'h200 + 32'(i - 6));
      chk("drain_ch", out_ch, i[0]);
      tick();
    end
    out_ready = 1'b0;
    chk("drain_empty", out_valid, 0);
    $display("full/backpressure sequence done");

    // Overflow handling
    push_pair(32'h8000_0001, 32'h5, 1'b1, 1'b0);
`ifdef GSB_CLIP_EN
    chk("ovr_level", level, 2);
    chk("ovr_data0", out_data, 32'h8000_0000);
    chk("ovr_ch0", out_ch, 0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
`else
    chk("ovr_level", level, 1);
`endif
    chk("ovr_data1", out_data, 32'h5);
    chk("ovr_ch1", out_ch, 1);
    chk("ovr_drop", drop_cnt, 1);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    push_pair(32'h123, 32'h7FFF_FFFE, 1'b1, 1'b1);
`ifdef GSB_CLIP_EN
    chk("clip_pos_data", out_data, 32'h7FFF_FFFF);
    chk("clip_level", level, 2);
    out_ready = 1'b1; tick(); tick(); out_ready = 1'b0;
`else
    chk("both_ovr_level", level, 0);
`endif
    chk("both_ovr_drop", drop_cnt, 3);
    chk("ovr_empty", out_valid, 0);
    $display("overflow pairs done, drop_cnt=%0d", drop_cnt);

    // Sustained streaming, 1000 pairs
    out_ready = 1'b1;
    r = 0; k = 0; lvl_m = 0; errs = 0; cyc = 0;
    while (r < 2000 && cyc < 5000) begin
      if (level !== 4'(lvl_m)) errs++;
      if (out_valid) begin
        if (out_data !== 32'(r) || out_ch !== r[0]) errs++;
        r++;
      end
      in_valid = (k < 1000);
      in_s1 = 32'(2*k); in_s2 = 32'(2*k + 1);
      push_now = in_valid && in_ready;
      if (push_now) k++;
      lvl_m = lvl_m + (push_now ? 2 : 0) - ((lvl_m != 0) ? 1 : 0);
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("stream_count", r, 2000);
    chk("stream_errs", errs, 0);
    chk("stream_level", level, 0);
    $display("stream: %0d samples in %0d cycles", r, cyc);

    // Drop counter saturation on a 4-bit counter
    b_in_valid = 1'b1;
`ifdef GSB_CLIP_EN
    b_out_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
`else
    for (int i = 0; i < 7; i++) tick();
    chk("sat_mid", b_drop, 4'hE);
    for (int i = 0; i < 13; i++) tick();
    chk("sat_level", b_level, 0);
`endif
    b_in_valid = 1'b0;
    chk("sat_drop", b_drop, 4'hF);
    $display("narrow drop counter = %0h", b_drop);

    // Reset during push+pop at level 5
    push_pair(32'h300, 32'h301, 1'b0, 1'b0);
    push_pair(32'h302, 32'h303, 1'b0, 1'b0);
    push_pair(32'h304, 32'h305, 1'b1, 1'b0);
`ifdef GSB_CLIP_EN
    chk("pre_rst_level", level, 6);
`else
    chk("pre_rst_level", level, 5);
`endif
    in_valid = 1'b1; in_s1 = 32'h400; in_s2 = 32'h401;
    out_ready = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("rst2_level", level, 0);
    chk("rst2_valid", out_valid, 0);
    chk("rst2_drop", drop_cnt, 0);
    chk("rst2_ready", in_ready, 1);
    push_pair(32'hAA, 32'hBB, 1'b0, 1'b0);
    chk("post_rst_data", out_data, 32'hAA);
    chk("post_rst_level", level, 2);
    $display("reset mid-traffic done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
